// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   ptr_w(depth) : width of a read/write pointer that addresses depth words
//   cnt_w(depth) : width of an occupancy counter that can hold 0..depth
//   FIFO_MODE_*  : read-mode selectors for the FWFT parameter
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// -----------------------------------------------------------------------------
// fifo_ptr_wrap
// Storage-address pointer that advances on en and wraps DEPTH-1 -> 0
// explicitly, so non-power-of-two depths index only valid words.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (pointer -> 0)
//   clr : synchronous clear, wins over en
//   en  : advance by one word
//   ptr : current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr_wrap
   import fifo_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      en,
   output logic [ptr_w(DEPTH)-1:0]   ptr
);

   localparam int PW = ptr_w(DEPTH);

   logic [PW-1:0] ptr_d;
   logic [PW-1:0] ptr_q;

   // Next pointer: clear, wrap at the last word, or step by one.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = {PW{1'b0}};
      end else if (en) begin
         if (ptr_q == PW'(DEPTH - 1)) begin
            ptr_d = {PW{1'b0}};
         end else begin
            ptr_d = ptr_q + PW'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= {PW{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Single-clock FIFO of arbitrary depth with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow and a synchronous
// flush. Read side is either registered (1-cycle latency) or FWFT.
// Ports:
//   clk, rst (async active-low), clr (sync flush, highest priority)
//   w_en/WR   : write request and data
//   r_en/RD   : read request (pop) and data
//   FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY : decoded from registered count
//   COUNT     : occupancy 0..DEPTH
//   OVERFLOW, UNDERFLOW : sticky rejected-access flags
// -----------------------------------------------------------------------------
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter int FWFT       = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      w_en,
   input  logic [DATA_WIDTH-1:0]     WR,
   input  logic                      r_en,
   output logic [DATA_WIDTH-1:0]     RD,
   output logic                      FULL,
   output logic                      EMPTY,
   output logic                      ALMOST_FULL,
   output logic                      ALMOST_EMPTY,
   output logic [cnt_w(DEPTH)-1:0]   COUNT,
   output logic                      OVERFLOW,
   output logic                      UNDERFLOW
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_sync_param: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_param: AE_THRESH must be in 0..DEPTH-1");
   end
   if (FWFT != FIFO_MODE_REG && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("fifo_sync_param: FWFT must be 0 or 1");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         w_ptr_s;
   logic [PW-1:0]         r_ptr_s;
   logic                  rd_ok_s;
   logic                  wr_ok_s;

   logic [CW-1:0] count_d, count_q;
   logic          full_d, full_q;
   logic          empty_d, empty_q;
   logic          af_d, af_q;
   logic          ae_d, ae_q;
   logic          ovf_d, ovf_q;
   logic          udf_d, udf_q;

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_ok_s = r_en & ~empty_q;
   assign wr_ok_s = w_en & (~full_q | rd_ok_s);

   fifo_ptr_wrap #(.DEPTH(DEPTH)) u_w_ptr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (wr_ok_s),
      .ptr (w_ptr_s)
   );

   fifo_ptr_wrap #(.DEPTH(DEPTH)) u_r_ptr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (rd_ok_s),
      .ptr (r_ptr_s)
   );

   // Storage write; contents survive reset and flush.
   always_ff @(posedge clk) begin
      if (wr_ok_s && !clr) begin
         mem_q[w_ptr_s] <= WR;
      end
   end

   // Occupancy, flag decode of the next count, and sticky error flags.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (clr) begin
         count_d = {CW{1'b0}};
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else begin
         case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         ovf_d = ovf_q | (w_en & ~wr_ok_s);
         udf_d = udf_q | (r_en & ~rd_ok_s);
      end
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == {CW{1'b0}});
      af_d    = (count_d >= CW'(AF_THRESH));
      ae_d    = (count_d <= CW'(AE_THRESH));
   end

   // Status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= {CW{1'b0}};
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         af_q    <= af_d;
         ae_q    <= ae_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is always presented; stale while EMPTY.
      assign RD = mem_q[r_ptr_s];
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_d, rd_q;

      // Output register loads the head on a pop and holds otherwise.
      always_comb begin
         rd_d = rd_q;
         if (clr) begin
            rd_d = {DATA_WIDTH{1'b0}};
         end else if (rd_ok_s) begin
            rd_d = mem_q[r_ptr_s];
         end else begin
            rd_d = rd_q;
         end
      end

      // Read data register.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rd_q <= {DATA_WIDTH{1'b0}};
         end else begin
            rd_q <= rd_d;
         end
      end

      assign RD = rd_q;
   end

   assign COUNT        = count_q;
   assign FULL         = full_q;
   assign EMPTY        = empty_q;
   assign ALMOST_FULL  = af_q;
   assign ALMOST_EMPTY = ae_q;
   assign OVERFLOW     = ovf_q;
   assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
// Directed bench for fifo_sync_param (DEPTH=5, AF=4, AE=1). Two instances share
// stimulus: u_reg in registered-read mode and u_fwft in first-word-fall-through.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       w_en;
   logic       r_en;
   logic [7:0] wr;

   logic [7:0] rd0, rd1;
   logic       full0, empty0, af0, ae0, ovf0, udf0;
   logic       full1, empty1, af1, ae1, ovf1, udf1;
   logic [2:0] cnt0, cnt1;
   logic [3:0] fl0;

   int total = 0;
   int bad   = 0;

   assign fl0 = {full0, af0, ae0, empty0};

   always #5 clk = ~clk;

   fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_reg (
      .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .WR(wr), .r_en(r_en), .RD(rd0),
      .FULL(full0), .EMPTY(empty0), .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0),
      .COUNT(cnt0), .OVERFLOW(ovf0), .UNDERFLOW(udf0)
   );

   fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .WR(wr), .r_en(r_en), .RD(rd1),
      .FULL(full1), .EMPTY(empty1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1),
      .COUNT(cnt1), .OVERFLOW(ovf1), .UNDERFLOW(udf1)
   );

   // Expected {FULL, ALMOST_FULL, ALMOST_EMPTY, EMPTY} for an occupancy c.
   function automatic logic [3:0] exp_flags(input int c);
      return {(c == 5), (c >= 4), (c <= 1), (c == 0)};
   endfunction

   // One clock with the given inputs, then sample #1 after the edge.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
      w_en = w; wr = d; r_en = r; clr = c;
      @(posedge clk);
      #1;
      w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; wr = 8'h00;
      #12;
      total++;
      if ({fl0, cnt0, ovf0, udf0, rd0} !== {4'b0011, 3'd0, 1'b0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reset_state got=%b/%0d/%b/%b/%h exp=0011/0/0/0/00", fl0, cnt0, ovf0, udf0, rd0);
      end
      rst = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      total++;
      if ({full1, af1, ae1, empty1, cnt1} !== {4'b0011, 3'd0}) begin
         bad++;
         $display("FAIL reset_fwft got=%b%b%b%b/%0d exp=0011/0", full1, af1, ae1, empty1, cnt1);
      end
   endtask

   task automatic test_fill;
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1, 8'(8'h11 * k), 1'b0, 1'b0);
         total++;
         if ({cnt0, fl0, ovf0} !== {3'(k), exp_flags(k), 1'b0}) begin
            bad++;
            $display("FAIL fill_k%0d got cnt=%0d fl=%b ovf=%b exp cnt=%0d fl=%b ovf=0",
                     k, cnt0, fl0, ovf0, k, exp_flags(k));
         end
      end
      cyc(1'b1, 8'h66, 1'b0, 1'b0);
      total++;
      if ({cnt0, fl0, ovf0, ovf1} !== {3'd5, 4'b1100, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL fill_overflow got cnt=%0d fl=%b ovf=%b/%b exp 5/1100/1/1", cnt0, fl0, ovf0, ovf1);
      end
      total++;
      if (rd1 !== 8'h11) begin
         bad++;
         $display("FAIL fill_fwft_head got=%h exp=11", rd1);
      end
   endtask

   task automatic test_drain;
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if ({rd0, cnt0, fl0} !== {8'(8'h11 * k), 3'(5 - k), exp_flags(5 - k)}) begin
            bad++;
            $display("FAIL drain_k%0d got rd=%h cnt=%0d fl=%b exp rd=%h cnt=%0d fl=%b",
                     k, rd0, cnt0, fl0, 8'(8'h11 * k), 5 - k, exp_flags(5 - k));
         end
         if (k < 5) begin
            total++;
            if (rd1 !== 8'(8'h11 * (k + 1))) begin
               bad++;
               $display("FAIL drain_fwft_k%0d got=%h exp=%h", k, rd1, 8'(8'h11 * (k + 1)));
            end
         end
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if ({udf0, rd0, cnt0, empty0} !== {1'b1, 8'h55, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL drain_underflow got udf=%b rd=%h cnt=%0d empty=%b exp 1/55/0/1", udf0, rd0, cnt0, empty0);
      end
   endtask

   task automatic test_wrap;
      logic [7:0] b [5];
      b[0] = 8'hB1; b[1] = 8'hB2; b[2] = 8'hB3; b[3] = 8'hB4; b[4] = 8'hB5;
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if ({ovf0, udf0, ovf1, udf1} !== 4'b0000) begin
         bad++;
         $display("FAIL wrap_clr_flags got=%b%b%b%b exp=0000", ovf0, udf0, ovf1, udf1);
      end
      for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'hA1 + k), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (rd0 !== 8'(8'hA1 + k)) begin
            bad++;
            $display("FAIL wrap_pre_k%0d got=%h exp=%h", k, rd0, 8'(8'hA1 + k));
         end
      end
      for (int k = 0; k < 5; k++) cyc(1'b1, b[k], 1'b0, 1'b0);
      total++;
      if ({cnt0, fl0, ovf0} !== {3'd5, 4'b1100, 1'b0}) begin
         bad++;
         $display("FAIL wrap_full got cnt=%0d fl=%b ovf=%b exp 5/1100/0", cnt0, fl0, ovf0);
      end
      for (int k = 0; k < 5; k++) begin
         total++;
         if (rd1 !== b[k]) begin
            bad++;
            $display("FAIL wrap_fwft_k%0d got=%h exp=%h", k, rd1, b[k]);
         end
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (rd0 !== b[k]) begin
            bad++;
            $display("FAIL wrap_read_k%0d got=%h exp=%h", k, rd0, b[k]);
         end
      end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'hC1 + k), 1'b0, 1'b0);
      cyc(1'b1, 8'hC6, 1'b1, 1'b0);
      total++;
      if ({cnt0, fl0, rd0, ovf0} !== {3'd5, 4'b1100, 8'hC1, 1'b0}) begin
         bad++;
         $display("FAIL b2b_full got cnt=%0d fl=%b rd=%h ovf=%b exp 5/1100/c1/0", cnt0, fl0, rd0, ovf0);
      end
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (rd0 !== 8'(8'hC2 + k)) begin
            bad++;
            $display("FAIL b2b_drain_k%0d got=%h exp=%h", k, rd0, 8'(8'hC2 + k));
         end
      end
      cyc(1'b1, 8'hD1, 1'b1, 1'b0);
      total++;
      if ({cnt0, fl0, udf0, rd0, ovf0} !== {3'd1, 4'b0010, 1'b1, 8'hC6, 1'b0}) begin
         bad++;
         $display("FAIL b2b_empty got cnt=%0d fl=%b udf=%b rd=%h ovf=%b exp 1/0010/1/c6/0",
                  cnt0, fl0, udf0, rd0, ovf0);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if ({rd0, cnt0} !== {8'hD1, 3'd0}) begin
         bad++;
         $display("FAIL b2b_after got rd=%h cnt=%0d exp d1/0", rd0, cnt0);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_fwft;
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      total++;
      if ({empty1, rd1, cnt1} !== {1'b0, 8'hA5, 3'd1}) begin
         bad++;
         $display("FAIL fwft_fall got empty=%b rd=%h cnt=%0d exp 0/a5/1", empty1, rd1, cnt1);
      end
      cyc(1'b1, 8'h5A, 1'b0, 1'b0);
      total++;
      if (rd1 !== 8'hA5) begin
         bad++;
         $display("FAIL fwft_head_hold got=%h exp=a5", rd1);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if ({rd1, cnt1, rd0} !== {8'h5A, 3'd1, 8'hA5}) begin
         bad++;
         $display("FAIL fwft_pop1 got fwft=%h cnt=%0d reg=%h exp 5a/1/a5", rd1, cnt1, rd0);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if ({empty1, cnt1, udf1} !== {1'b1, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL fwft_pop2 got empty=%b cnt=%0d udf=%b exp 1/0/0", empty1, cnt1, udf1);
      end
   endtask

   task automatic test_clear;
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'hE1 + k), 1'b0, 1'b0);
      cyc(1'b1, 8'hE6, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if ({cnt0, ovf0, udf0, rd0} !== {3'd3, 1'b1, 1'b1, 8'hE2}) begin
         bad++;
         $display("FAIL clr_setup got cnt=%0d ovf=%b udf=%b rd=%h exp 3/1/1/e2", cnt0, ovf0, udf0, rd0);
      end
      cyc(1'b1, 8'hFF, 1'b0, 1'b1);
      total++;
      if ({cnt0, fl0, ovf0, udf0, rd0} !== {3'd0, 4'b0011, 1'b0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL clr_sync got cnt=%0d fl=%b ovf=%b udf=%b rd=%h exp 0/0011/0/0/00",
                  cnt0, fl0, ovf0, udf0, rd0);
      end
      cyc(1'b1, 8'h77, 1'b0, 1'b0);
      total++;
      if ({rd1, cnt1} !== {8'h77, 3'd1}) begin
         bad++;
         $display("FAIL clr_next_write got rd=%h cnt=%0d exp 77/1", rd1, cnt1);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if ({rd0, empty0} !== {8'h77, 1'b1}) begin
         bad++;
         $display("FAIL clr_next_read got rd=%h empty=%b exp 77/1", rd0, empty0);
      end
      // Async reset mid-cycle.
      for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'hF1 + k), 1'b0, 1'b0);
      cyc(1'b1, 8'hF6, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({cnt0, fl0, ovf0, udf0, rd0, ovf1} !== {3'd0, 4'b0011, 1'b0, 1'b0, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL rst_async got cnt=%0d fl=%b ovf=%b udf=%b rd=%h ovf1=%b exp 0/0011/0/0/00/0",
                  cnt0, fl0, ovf0, udf0, rd0, ovf1);
      end
      #2;
      rst = 1'b1;
      cyc(1'b1, 8'h88, 1'b0, 1'b0);
      total++;
      if ({rd1, cnt1} !== {8'h88, 3'd1}) begin
         bad++;
         $display("FAIL rst_next_write got rd=%h cnt=%0d exp 88/1", rd1, cnt1);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if ({rd0, cnt0} !== {8'h88, 3'd0}) begin
         bad++;
         $display("FAIL rst_next_read got rd=%h cnt=%0d exp 88/0", rd0, cnt0);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_back_to_back();
      test_fwft();
      test_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
